// File: rtl/pong_pkg.sv
// Shared definitions for the two-player Pong engine.
// Provides the game state encoding, the default position width and a
// helper that computes the centred coordinate of an object on an axis.
package pong_pkg;

   // Game state encoding; the numeric values are visible on the state port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam int POS_W_DEFAULT = 10;

   // Top-left coordinate that centres an object of the given size on an axis.
   function automatic int centre(input int extent, input int size);
      return (extent - size) / 2;
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One vertically moving paddle, clamped to the playfield.
// Ports:
//   clk_i    clock
//   rst_n_i  synchronous active-low reset (paddle returns to vertical centre)
//   en_i     update strobe; the paddle only moves when this is high
//   up_i     move up (wins over down_i when both are set)
//   down_i   move down
//   speed_i  pixels moved per strobe
//   y_o      top edge of the paddle
module pong_paddle
   import pong_pkg::*;
#(
   parameter int POS_W    = POS_W_DEFAULT,
   parameter int SCREEN_H = 480,
   parameter int PADDLE_H = 60
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             down_i,
   input  logic [POS_W-1:0] speed_i,
   output logic [POS_W-1:0] y_o
);

   localparam logic [POS_W:0]   Y_MAX   = (POS_W+1)'(SCREEN_H - PADDLE_H);
   localparam logic [POS_W-1:0] Y_RESET = POS_W'(centre(SCREEN_H, PADDLE_H));

   logic [POS_W-1:0] y_q, y_d;
   logic [POS_W:0]   downSum;

   // Next position: the subtraction is guarded so it never underflows, and the
   // addition is done one bit wider so the clamp compare cannot overflow.
   always_comb begin
      y_d     = y_q;
      downSum = {1'b0, y_q} + {1'b0, speed_i};
      if (up_i) begin
         y_d = (y_q < speed_i) ? '0 : y_q - speed_i;
      end else if (down_i) begin
         y_d = (downSum > Y_MAX) ? Y_MAX[POS_W-1:0] : downSum[POS_W-1:0];
      end
   end

   // Position register, only advanced on an enabled strobe.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         y_q <= Y_RESET;
      end else if (en_i) begin
         y_q <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/pong_core.sv
// Two-player Pong engine: ball physics, paddles, scoring, serve delay and
// win detection. Physics advances only on the internal tick pulse.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      level; starts a game from IDLE or restarts from OVER
//   p1_up, p1_down             left paddle buttons
//   p2_up, p2_down             right paddle buttons (ignored while ai_en=1)
//   ai_en                      right paddle follows the ball automatically
//   ball_x, ball_y             ball top-left corner
//   paddle_l_y, paddle_r_y     paddle top edges
//   score_l, score_r           player scores
//   ball_dir_x, ball_dir_y     1 = moving right / down
//   state                      0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
//   tick                       one-cycle physics strobe
module pong_core
   import pong_pkg::*;
#(
   parameter int POS_W        = POS_W_DEFAULT,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int BALL_SIZE    = 10,
   parameter int PADDLE_W     = 10,
   parameter int PADDLE_H     = 60,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 2,
   parameter int AI_SPEED     = 1,
   parameter int TICK_DIV_W   = 16,
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_TICKS  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               p1_up,
   input  logic               p1_down,
   input  logic               p2_up,
   input  logic               p2_down,
   input  logic               ai_en,
   output logic [POS_W-1:0]   ball_x,
   output logic [POS_W-1:0]   ball_y,
   output logic [POS_W-1:0]   paddle_l_y,
   output logic [POS_W-1:0]   paddle_r_y,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic               ball_dir_x,
   output logic               ball_dir_y,
   output logic [1:0]         state,
   output logic               tick
);

   localparam int SCW = $clog2(SERVE_TICKS + 1);

   localparam logic [POS_W-1:0]   BALL_X0   = POS_W'(centre(SCREEN_W, BALL_SIZE));
   localparam logic [POS_W-1:0]   BALL_Y0   = POS_W'(centre(SCREEN_H, BALL_SIZE));
   localparam logic [POS_W-1:0]   SPD       = POS_W'(BALL_SPEED);
   localparam logic [POS_W-1:0]   X_LSTOP   = POS_W'(PADDLE_W);
   localparam logic [POS_W-1:0]   X_RSTOP   = POS_W'(SCREEN_W - PADDLE_W - BALL_SIZE);
   localparam logic [POS_W-1:0]   Y_BOTTOM  = POS_W'(SCREEN_H - BALL_SIZE);
   localparam logic [SCW-1:0]     SERVE_END = SCW'(SERVE_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

   // Compare thresholds, one bit wider than positions.
   localparam logic [POS_W:0] W_BSIZE  = (POS_W+1)'(BALL_SIZE);
   localparam logic [POS_W:0] W_PH     = (POS_W+1)'(PADDLE_H);
   localparam logic [POS_W:0] W_BHALF  = (POS_W+1)'(BALL_SIZE / 2);
   localparam logic [POS_W:0] W_PHALF  = (POS_W+1)'(PADDLE_H / 2);
   localparam logic [POS_W:0] L_HIT_LO = (POS_W+1)'(PADDLE_W);
   localparam logic [POS_W:0] L_HIT_HI = (POS_W+1)'(PADDLE_W + BALL_SPEED);
   localparam logic [POS_W:0] L_MISS   = (POS_W+1)'(BALL_SPEED);
   localparam logic [POS_W:0] R_HIT_LO = (POS_W+1)'(SCREEN_W - PADDLE_W - BALL_SIZE - BALL_SPEED);
   localparam logic [POS_W:0] R_HIT_HI = (POS_W+1)'(SCREEN_W - PADDLE_W - BALL_SIZE);
   localparam logic [POS_W:0] R_MISS   = (POS_W+1)'(SCREEN_W - BALL_SIZE - BALL_SPEED);
   localparam logic [POS_W:0] Y_TOP    = (POS_W+1)'(BALL_SPEED);
   localparam logic [POS_W:0] Y_BOT    = (POS_W+1)'(SCREEN_H - BALL_SIZE - BALL_SPEED);

   logic [TICK_DIV_W-1:0] div_q;
   state_t                state_q;
   logic [SCW-1:0]        serveCnt_q;
   logic [POS_W-1:0]      ballX_q, ballY_q;
   logic                  dirX_q, dirY_q;
   logic [SCORE_W-1:0]    scoreL_q, scoreR_q;

   logic                  tickNow;
   logic [POS_W-1:0]      padL, padR;
   logic [POS_W:0]        bx, by, plW, prW;
   logic                  overlapL, overlapR;
   logic                  leftHit, leftMiss, rightHit, rightMiss;
   logic [POS_W-1:0]      ballX_d, ballY_d;
   logic                  dirX_d, dirY_d;
   logic [SCORE_W-1:0]    scoreLInc, scoreRInc;
   logic                  padEn, rUp, rDown;
   logic [POS_W-1:0]      rSpeed;

   assign tickNow   = &div_q;
   assign bx        = {1'b0, ballX_q};
   assign by        = {1'b0, ballY_q};
   assign plW       = {1'b0, padL};
   assign prW       = {1'b0, padR};
   assign overlapL  = (by + W_BSIZE > plW) && (by < plW + W_PH);
   assign overlapR  = (by + W_BSIZE > prW) && (by < prW + W_PH);
   assign scoreLInc = scoreL_q + 1'b1;
   assign scoreRInc = scoreR_q + 1'b1;

   // Classify the ball's X situation; hits take precedence over misses.
   assign leftHit   = !dirX_q && (bx >= L_HIT_LO) && (bx <= L_HIT_HI) && overlapL;
   assign leftMiss  = !dirX_q && !leftHit && (bx <= L_MISS);
   assign rightHit  = dirX_q && (bx >= R_HIT_LO) && (bx <= R_HIT_HI) && overlapR;
   assign rightMiss = dirX_q && !rightHit && (bx >= R_MISS);

   // Rally motion for a PLAY tick without a miss. X and Y are independent,
   // so a corner hit applies both bounces in the same tick.
   always_comb begin
      ballX_d = ballX_q;
      dirX_d  = dirX_q;
      ballY_d = ballY_q;
      dirY_d  = dirY_q;
      if (leftHit) begin
         ballX_d = X_LSTOP;
         dirX_d  = 1'b1;
      end else if (rightHit) begin
         ballX_d = X_RSTOP;
         dirX_d  = 1'b0;
      end else if (dirX_q) begin
         ballX_d = ballX_q + SPD;
      end else begin
         ballX_d = ballX_q - SPD;
      end
      if (!dirY_q && (by <= Y_TOP)) begin
         ballY_d = '0;
         dirY_d  = 1'b1;
      end else if (dirY_q && (by >= Y_BOT)) begin
         ballY_d = Y_BOTTOM;
         dirY_d  = 1'b0;
      end else if (dirY_q) begin
         ballY_d = ballY_q + SPD;
      end else begin
         ballY_d = ballY_q - SPD;
      end
   end

   // Right paddle source: the AI steers the paddle centre toward the ball centre.
   always_comb begin
      padEn  = tickNow && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
      rUp    = p2_up;
      rDown  = p2_down;
      rSpeed = POS_W'(PADDLE_SPEED);
      if (ai_en) begin
         rUp    = (by + W_BHALF) < (prW + W_PHALF);
         rDown  = (by + W_BHALF) > (prW + W_PHALF);
         rSpeed = POS_W'(AI_SPEED);
      end
   end

   pong_paddle #(
      .POS_W    (POS_W),
      .SCREEN_H (SCREEN_H),
      .PADDLE_H (PADDLE_H)
   ) uPaddleL (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (padEn),
      .up_i    (p1_up),
      .down_i  (p1_down),
      .speed_i (POS_W'(PADDLE_SPEED)),
      .y_o     (padL)
   );

   pong_paddle #(
      .POS_W    (POS_W),
      .SCREEN_H (SCREEN_H),
      .PADDLE_H (PADDLE_H)
   ) uPaddleR (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (padEn),
      .up_i    (rUp),
      .down_i  (rDown),
      .speed_i (rSpeed),
      .y_o     (padR)
   );

   // Game state machine with ball, score and serve registers. Only the
   // IDLE->SERVE transition may happen outside a tick cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q      <= '0;
         state_q    <= ST_IDLE;
         serveCnt_q <= '0;
         ballX_q    <= BALL_X0;
         ballY_q    <= BALL_Y0;
         dirX_q     <= 1'b1;
         dirY_q     <= 1'b1;
         scoreL_q   <= '0;
         scoreR_q   <= '0;
      end else begin
         div_q <= div_q + 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_SERVE;
                  serveCnt_q <= '0;
               end
            end
            ST_SERVE: begin
               if (tickNow) begin
                  if (serveCnt_q == SERVE_END) begin
                     state_q    <= ST_PLAY;
                     serveCnt_q <= '0;
                  end else begin
                     serveCnt_q <= serveCnt_q + 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (tickNow) begin
                  if (leftMiss) begin
                     scoreR_q   <= scoreRInc;
                     ballX_q    <= BALL_X0;
                     ballY_q    <= BALL_Y0;
                     dirX_q     <= 1'b0;
                     dirY_q     <= ~dirY_q;
                     serveCnt_q <= '0;
                     state_q    <= (scoreRInc == WIN) ? ST_OVER : ST_SERVE;
                  end else if (rightMiss) begin
                     scoreL_q   <= scoreLInc;
                     ballX_q    <= BALL_X0;
                     ballY_q    <= BALL_Y0;
                     dirX_q     <= 1'b1;
                     dirY_q     <= ~dirY_q;
                     serveCnt_q <= '0;
                     state_q    <= (scoreLInc == WIN) ? ST_OVER : ST_SERVE;
                  end else begin
                     ballX_q <= ballX_d;
                     ballY_q <= ballY_d;
                     dirX_q  <= dirX_d;
                     dirY_q  <= dirY_d;
                  end
               end
            end
            ST_OVER: begin
               if (tickNow && start) begin
                  scoreL_q   <= '0;
                  scoreR_q   <= '0;
                  ballX_q    <= BALL_X0;
                  ballY_q    <= BALL_Y0;
                  dirX_q     <= 1'b1;
                  serveCnt_q <= '0;
                  state_q    <= ST_SERVE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ball_x     = ballX_q;
   assign ball_y     = ballY_q;
   assign paddle_l_y = padL;
   assign paddle_r_y = padR;
   assign score_l    = scoreL_q;
   assign score_r    = scoreR_q;
   assign ball_dir_x = dirX_q;
   assign ball_dir_y = dirY_q;
   assign state      = state_q;
   assign tick       = tickNow;

endmodule

// File: doc/pong_core.md
Name: pong_core

Overview:
Parametrised two-player Pong engine that generalises the single-paddle bouncing-ball block.
- Left paddle: player 1 buttons.
- Right paddle: player 2 buttons, or a built-in tracking AI.
- Adds scoring, serve delay, win detection and a game state machine.
- Feeds the video renderer with object positions and the score display with counters. All logic runs in the clk domain; physics advances only on an internal tick pulse.

Parameters:
POS_W, 10, width of all position signals
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 10, ball edge length (ball_x/ball_y are its top-left corner)
PADDLE_W, 10, paddle width; left paddle occupies x 0..PADDLE_W-1, right paddle SCREEN_W-PADDLE_W..SCREEN_W-1
PADDLE_H, 60, paddle height
BALL_SPEED, 2, ball pixels per tick per axis
PADDLE_SPEED, 2, human paddle pixels per tick
AI_SPEED, 1, AI paddle pixels per tick
TICK_DIV_W, 16, tick period = 2^TICK_DIV_W clocks
SCORE_W, 4, score counter width
WIN_SCORE, 9, score that ends the game
SERVE_TICKS, 32, ticks the ball waits at centre before moving

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  level; starts or restarts a game
p1_up  in  1  left paddle up
p1_down  in  1  left paddle down
p2_up  in  1  right paddle up (ignored when ai_en=1)
p2_down  in  1  right paddle down (ignored when ai_en=1)
ai_en  in  1  1 = right paddle driven by AI
ball_x  out  POS_W  ball left edge
ball_y  out  POS_W  ball top edge
paddle_l_y  out  POS_W  left paddle top edge
paddle_r_y  out  POS_W  right paddle top edge
score_l  out  SCORE_W  left player score
score_r  out  SCORE_W  right player score
ball_dir_x  out  1  1 = moving right
ball_dir_y  out  1  1 = moving down
state  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
tick  out  1  one-cycle pulse, physics update strobe

Behaviour:
- Reset values:
  - Divider 0; tick 0.
  - ball_x = (SCREEN_W-BALL_SIZE)/2, ball_y = (SCREEN_H-BALL_SIZE)/2.
  - Both paddles (SCREEN_H-PADDLE_H)/2.
  - Scores 0; ball_dir_x=1, ball_dir_y=1; state IDLE; serve counter 0.
- Tick: free-running TICK_DIV_W-bit divider. tick=1 in the cycle the divider is all-ones. All position/score/state changes except IDLE->SERVE happen in a tick cycle and are visible the next cycle.
- State machine:
  - IDLE:
    - start=1 (any cycle) -> SERVE; serve counter cleared.
  - SERVE:
    - Ball held at centre.
    - Serve counter increments per tick; on the tick where it equals SERVE_TICKS-1 -> PLAY.
  - PLAY: ball moves per rules below.
  - OVER:
    - Everything frozen.
    - start=1 -> scores cleared, ball centred, ball_dir_x=1 -> SERVE.
  - start is ignored in SERVE and PLAY.
- Paddles (SERVE and PLAY only, per tick):
  - Up has priority when both buttons are pressed.
  - Up: y = (y < speed) ? 0 : y - speed.
  - Down: y = min(y + speed, SCREEN_H-PADDLE_H).
  - AI: compares ball centre (ball_y+BALL_SIZE/2) with paddle centre (y+PADDLE_H/2). Less -> up by AI_SPEED; greater -> down by AI_SPEED; equal -> hold.
  - ai_en sampled each tick; switching mid-game is legal.
- Overlap(p): ball_y+BALL_SIZE > p AND ball_y < p+PADDLE_H.
- Ball X axis, per PLAY tick, first match wins:
  - Left hit: dir_x=0, PADDLE_W <= ball_x <= PADDLE_W+BALL_SPEED, Overlap(paddle_l_y) -> ball_x=PADDLE_W, dir_x=1.
  - Left miss: dir_x=0, ball_x <= BALL_SPEED -> score_r+1, ball centred, dir_x=0 (serve toward the conceding left player), dir_y toggles -> SERVE.
  - Right hit: dir_x=1, SCREEN_W-PADDLE_W-BALL_SIZE-BALL_SPEED <= ball_x <= SCREEN_W-PADDLE_W-BALL_SIZE, Overlap(paddle_r_y) -> ball_x=SCREEN_W-PADDLE_W-BALL_SIZE, dir_x=0.
  - Right miss: dir_x=1, ball_x >= SCREEN_W-BALL_SIZE-BALL_SPEED -> score_l+1, centre, dir_x=1, dir_y toggles -> SERVE.
  - Otherwise: ball_x ± BALL_SPEED.
- Ball Y axis, per PLAY tick, evaluated in the same tick as X:
  - Moving up with ball_y <= BALL_SPEED -> ball_y=0, dir_y=1.
  - Moving down with ball_y >= SCREEN_H-BALL_SIZE-BALL_SPEED -> ball_y=SCREEN_H-BALL_SIZE, dir_y=0.
  - Otherwise: ball_y ± BALL_SPEED.
  - Corner hit (X and Y events in one tick): both apply.
  - A miss overrides the Y update (ball recentred).
- Scoring:
  - If the incremented score equals WIN_SCORE, go to OVER instead of SERVE. Score stays at WIN_SCORE; ball centred.
  - Scores never wrap; WIN_SCORE < 2^SCORE_W is required.
- Arithmetic: all compares are unsigned at POS_W+1 bits to avoid overflow; subtractions are guarded as above, so no underflow.
- rst_n=0 in any state (mid-rally, mid-serve) restores all reset values in the next cycle.

Decomposition:
- pong_pkg: state encoding constants (IDLE/SERVE/PLAY/OVER), position width, derived centre constants.
- Sub-module pong_paddle: one clamped paddle with up/down/speed inputs. Instantiated twice; the right instance's up/down is muxed from the AI or the p2 buttons.

Test Plan:
All scenarios use TICK_DIV_W=2 and SERVE_TICKS=4.
1. Reset, then start=1 for one cycle -> state SERVE next cycle; after 4 ticks state PLAY; ball_x 315->317 on first PLAY tick.
2. Hold p1_up for 200 ticks from reset position 210 -> paddle_l_y decreases 2 per tick, stops at 0; p1_up+p1_down together -> moves up.
3. ai_en=0, right paddle parked at 0, ball moving right at y=240 -> right miss at ball_x>=628; score_l=1, ball at (315,235), dir_x=1, dir_y toggled, state SERVE.
4. Left paddle at 210, ball dir_x=0 at x=12, y=230 -> next tick ball_x=10, dir_x=1, score unchanged.
5. Ball at y=2 moving up, x=12 moving left, left paddle overlapping -> single tick gives ball_y=0, dir_y=1, ball_x=10, dir_x=1.
6. Force score_l=8, trigger right miss -> score_l=9, state OVER, outputs frozen for 50 ticks; start=1 -> scores 0, SERVE; rst_n=0 mid-PLAY -> all reset values next cycle.
